// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencing controller:
// state encodings, default counter width and the IF/ID NOP.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_HALT     = 2'd2
    } fetch_state_e;

    localparam int CNT_W_DEF = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset (async, high), increment, clear, value.
module sat_counter #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             increment,
    input  logic             clear,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_value <= '0;
        end else if (clear) begin
            r_value <= '0;
        end else if (increment && (r_value != MAX_VAL)) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign value = r_value;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencing controller: PC enable/mux, IF/ID
// write/flush, redirect target latch, stall watchdog and
// saturating redirect/stall statistics.
// Ports: clk, reset; in branchTaken, branchTarget,
// hazardStall, haltDetected, resume; out pcWrite, muxSel,
// targetOut, ifIdWrite, ifIdFlush, state, redirectCount,
// stallCount, stallError.
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int STALL_LIMIT = 8,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branchTaken,
    input  logic [31:0]      branchTarget,
    input  logic             hazardStall,
    input  logic             haltDetected,
    input  logic             resume,
    output logic             pcWrite,
    output logic             muxSel,
    output logic [31:0]      targetOut,
    output logic             ifIdWrite,
    output logic             ifIdFlush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] redirectCount,
    output logic [CNT_W-1:0] stallCount,
    output logic             stallError
);

    localparam int CW = $clog2(STALL_LIMIT + 1);

    fetch_state_e r_state;
    fetch_state_e w_next;
    logic [31:0]  r_target;
    logic         r_err;
    logic         w_redirect;
    logic         w_stall;
    logic         w_in_run;
    logic [CW-1:0] w_consec;

    // Illegal encoding 2'd3 drives RUN outputs but takes no
    // RUN side effects; it simply falls back to RUN.
    always_comb begin
        pcWrite    = 1'b0;
        muxSel     = 1'b0;
        ifIdWrite  = 1'b0;
        ifIdFlush  = 1'b0;
        w_redirect = 1'b0;
        w_stall    = 1'b0;
        w_in_run   = 1'b0;
        w_next     = ST_RUN;
        unique case (1'b1)
            (r_state == ST_REDIRECT): begin
                muxSel    = 1'b1;
                pcWrite   = 1'b1;
                ifIdWrite = 1'b1;
                ifIdFlush = 1'b1;
            end
            (r_state == ST_HALT): begin
                w_next = resume ? ST_RUN : ST_HALT;
            end
            default: begin
                w_in_run = (r_state == ST_RUN);
                if (branchTaken) begin
                    ifIdWrite  = 1'b1;
                    ifIdFlush  = 1'b1;
                    w_redirect = w_in_run;
                    if (w_in_run) w_next = ST_REDIRECT;
                end else if (hazardStall) begin
                    w_stall = w_in_run;
                end else begin
                    pcWrite   = 1'b1;
                    ifIdWrite = 1'b1;
                    if (haltDetected && w_in_run) w_next = ST_HALT;
                end
            end
        endcase
        // Enables are held low for the whole reset window.
        if (reset) begin
            pcWrite   = 1'b0;
            muxSel    = 1'b0;
            ifIdWrite = 1'b0;
            ifIdFlush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_target <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_redirect) r_target <= branchTarget;
            // Set on the edge where the run length reaches the limit.
            if (w_stall && (w_consec >= CW'(STALL_LIMIT - 1)))
                r_err <= 1'b1;
        end
    end

    sat_counter #(
        .WIDTH   (CNT_W),
        .MAX_VAL ({CNT_W{1'b1}})
    ) u_redirect_cnt (
        .clk       (clk),
        .reset     (reset),
        .increment (w_redirect),
        .clear     (1'b0),
        .value     (redirectCount)
    );

    sat_counter #(
        .WIDTH   (CNT_W),
        .MAX_VAL ({CNT_W{1'b1}})
    ) u_stall_cnt (
        .clk       (clk),
        .reset     (reset),
        .increment (w_stall),
        .clear     (1'b0),
        .value     (stallCount)
    );

    sat_counter #(
        .WIDTH   (CW),
        .MAX_VAL (CW'(STALL_LIMIT))
    ) u_consec_cnt (
        .clk       (clk),
        .reset     (reset),
        .increment (w_stall),
        .clear     (w_in_run && !w_stall),
        .value     (w_consec)
    );

    assign targetOut  = r_target;
    assign stallError = r_err;
    assign state      = r_state;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller; second instance with
// 4-bit counters exercises redirect-count saturation.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        branchTaken;
    logic        b2;
    logic [31:0] branchTarget;
    logic        hazardStall;
    logic        haltDetected;
    logic        resume;

    logic        pcWrite, muxSel, ifIdWrite, ifIdFlush;
    logic        stallError;
    logic [31:0] targetOut;
    logic [1:0]  state;
    logic [15:0] redirectCount, stallCount;

    logic        s_pcWrite, s_muxSel, s_ifIdWrite, s_ifIdFlush;
    logic        s_stallError;
    logic [31:0] s_targetOut;
    logic [1:0]  s_state;
    logic [3:0]  s_redirectCount, s_stallCount;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk           (clk),
        .reset         (reset),
        .branchTaken   (branchTaken),
        .branchTarget  (branchTarget),
        .hazardStall   (hazardStall),
        .haltDetected  (haltDetected),
        .resume        (resume),
        .pcWrite       (pcWrite),
        .muxSel        (muxSel),
        .targetOut     (targetOut),
        .ifIdWrite     (ifIdWrite),
        .ifIdFlush     (ifIdFlush),
        .state         (state),
        .redirectCount (redirectCount),
        .stallCount    (stallCount),
        .stallError    (stallError)
    );

    fetch_controller #(.CNT_W(4)) u_sat (
        .clk           (clk),
        .reset         (reset),
        .branchTaken   (b2),
        .branchTarget  (branchTarget),
        .hazardStall   (hazardStall),
        .haltDetected  (haltDetected),
        .resume        (resume),
        .pcWrite       (s_pcWrite),
        .muxSel        (s_muxSel),
        .targetOut     (s_targetOut),
        .ifIdWrite     (s_ifIdWrite),
        .ifIdFlush     (s_ifIdFlush),
        .state         (s_state),
        .redirectCount (s_redirectCount),
        .stallCount    (s_stallCount),
        .stallError    (s_stallError)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        branchTaken  = 1'b0;
        b2           = 1'b0;
        branchTarget = 32'h0;
        hazardStall  = 1'b0;
        haltDetected = 1'b0;
        resume       = 1'b0;

        #3;
        chk("rst_pcw", pcWrite, 0);
        chk("rst_ifw", ifIdWrite, 0);
        chk("rst_mux", muxSel, 0);
        chk("rst_flush", ifIdFlush, 0);
        chk("rst_tgt", targetOut, 0);
        chk("rst_state", state, 0);
        chk("rst_err", stallError, 0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("post_pcw", pcWrite, 1);
        chk("post_state", state, 0);
        chk("post_rcnt", redirectCount, 0);
        chk("post_scnt", stallCount, 0);

        cyc();
        branchTaken  = 1'b1;
        branchTarget = 32'h10;
        #1;
        chk("brN_pcw", pcWrite, 0);
        chk("brN_flush", ifIdFlush, 1);
        chk("brN_mux", muxSel, 0);
        cyc();
        branchTaken = 1'b0;
        #1;
        chk("brN1_state", state, 1);
        chk("brN1_mux", muxSel, 1);
        chk("brN1_tgt", targetOut, 32'h10);
        chk("brN1_pcw", pcWrite, 1);
        chk("brN1_flush", ifIdFlush, 1);
        chk("brN1_rcnt", redirectCount, 1);
        cyc();
        chk("brN2_state", state, 0);
        chk("brN2_mux", muxSel, 0);

        branchTaken  = 1'b1;
        hazardStall  = 1'b1;
        branchTarget = 32'h20;
        #1;
        chk("bh_pcw", pcWrite, 0);
        chk("bh_flush", ifIdFlush, 1);
        cyc();
        hazardStall  = 1'b0;
        branchTarget = 32'h30;
        #1;
        chk("bh_scnt", stallCount, 0);
        chk("bh_state", state, 1);
        cyc();
        branchTaken = 1'b0;
        #1;
        chk("bh_tgt", targetOut, 32'h20);
        chk("bh_rcnt", redirectCount, 2);
        chk("bh_state2", state, 0);

        hazardStall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("stl_pcw", pcWrite, 0);
            chk("stl_ifw", ifIdWrite, 0);
            if (i == 7) chk("stl_err_pre", stallError, 0);
            cyc();
        end
        hazardStall = 1'b0;
        #1;
        chk("stl_scnt", stallCount, 8);
        chk("stl_err", stallError, 1);
        chk("stl_pcw_on", pcWrite, 1);
        cyc();
        chk("stl_err_hold", stallError, 1);
        chk("stl_scnt2", stallCount, 8);

        haltDetected = 1'b1;
        #1;
        chk("hlt_adv", pcWrite, 1);
        cyc();
        haltDetected = 1'b0;
        #1;
        chk("hlt_state", state, 2);
        chk("hlt_pcw", pcWrite, 0);
        branchTaken  = 1'b1;
        branchTarget = 32'h40;
        cyc();
        branchTaken = 1'b0;
        #1;
        chk("hlt_tgt", targetOut, 32'h20);
        chk("hlt_rcnt", redirectCount, 2);
        chk("hlt_state2", state, 2);
        resume = 1'b1;
        #1;
        chk("rsm_pcw0", pcWrite, 0);
        cyc();
        resume = 1'b0;
        #1;
        chk("rsm_state", state, 0);
        chk("rsm_pcw", pcWrite, 1);

        branchTaken  = 1'b1;
        branchTarget = 32'h50;
        cyc();
        branchTaken = 1'b0;
        #1;
        chk("mrr_mux", muxSel, 1);
        chk("mrr_tgt", targetOut, 32'h50);
        #1;
        reset = 1'b1;
        #1;
        chk("mrr_mux0", muxSel, 0);
        chk("mrr_tgt0", targetOut, 0);
        chk("mrr_state", state, 0);
        chk("mrr_rcnt", redirectCount, 0);
        chk("mrr_scnt", stallCount, 0);
        chk("mrr_err", stallError, 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("mrr_run", pcWrite, 1);

        for (int i = 0; i < 15; i++) begin
            b2 = 1'b1;
            cyc();
            b2 = 1'b0;
            cyc();
        end
        chk("sat_pre", s_redirectCount, 4'hF);
        b2 = 1'b1;
        cyc();
        b2 = 1'b0;
        #1;
        chk("sat_state", s_state, 1);
        chk("sat_hold", s_redirectCount, 4'hF);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
